// File: rtl/inject_sched_if.sv
// inject_sched_if: core-to-router injection bundle (enqueue side plus router port4 side)
interface inject_sched_if;
  logic         enq_valid;
  logic [15:0]  enq_dest;
  logic [127:0] enq_data;
  logic         enq_ready;
  logic         port4_ready;
  logic [27:0]  port4_ci;
  logic [127:0] port4_di;
  logic [15:0]  inj_count;
  logic [4:0]   q_level;
  modport master (
    output enq_valid, enq_dest, enq_data, port4_ready,
    input  enq_ready, port4_ci, port4_di, inj_count, q_level
  );
  modport slave (
    input  enq_valid, enq_dest, enq_data, port4_ready,
    output enq_ready, port4_ci, port4_di, inj_count, q_level
  );
endinterface

// File: rtl/inject_sched.sv
// inject_sched: circular flit queue feeding a router local-injection port with head-wait aging
module inject_sched #(
  parameter int         DEPTH   = 4,
  parameter logic [7:0] AGE_MAX = 8'hff
) (
  input logic           clk,
  input logic           rst,
  inject_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {EMPTY, WAIT, SEND} state_t;
  state_t          state;
  logic [15:0]     dest_q [DEPTH];
  logic [127:0]    data_q [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      level;
  logic [7:0]      head_age;
  logic            do_enq, do_deq;
  assign bus.enq_ready = level < 5'(DEPTH);
  assign bus.q_level   = level;
  // state is derived from registered occupancy, so a fresh enqueue cannot bypass to the output
  always_comb state = level == '0 ? EMPTY : bus.port4_ready ? SEND : WAIT;
  assign do_enq = bus.enq_valid && bus.enq_ready;
  assign do_deq = state == SEND;
  always_ff @(posedge clk)
    if (do_enq) begin
      dest_q[wr_ptr] <= bus.enq_dest;
      data_q[wr_ptr] <= bus.enq_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      head_age      <= '0;
      bus.inj_count <= '0;
      bus.port4_ci  <= '0;
      bus.port4_di  <= '0;
    end else begin
      wr_ptr        <= do_enq ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr        <= do_deq ? rd_ptr + AW'(1) : rd_ptr;
      level         <= level + 5'(do_enq) - 5'(do_deq);
      head_age      <= do_deq || (do_enq && state == EMPTY) ? 8'd0 :
                       state == WAIT && head_age < AGE_MAX ? head_age + 8'd1 : head_age;
      bus.inj_count <= bus.inj_count + 16'(do_deq);
      bus.port4_ci  <= do_deq ? {1'b1, 3'b000, head_age, dest_q[rd_ptr]} : 28'h0;
      bus.port4_di  <= do_deq ? data_q[rd_ptr] : 128'h0;
    end
endmodule
